// File: rtl/jump_flag_sender_if.sv
// Handshake bundle for jump_flag_sender: push side from ex plus the beat stream to the consumer.
interface jump_flag_sender_if #(
    parameter int ADDR_W = 32,
    parameter int OUT_W  = 8
);
    logic              start_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic [OUT_W-1:0]  result_o;
    logic              valid_o;
    logic              ready_i;
    logic              busy_o;
    logic              full_o;
    logic              overflow_o;

    // master: the surrounding logic (pusher and beat consumer); slave: the sender block
    modport master (
        output start_i, jump_addr_i, ready_i,
        input  result_o, valid_o, busy_o, full_o, overflow_o
    );

    modport slave (
        input  start_i, jump_addr_i, ready_i,
        output result_o, valid_o, busy_o, full_o, overflow_o
    );
endinterface

// File: rtl/jump_flag_sender.sv
// Queues jump targets and serialises each into ADDR_W/OUT_W beats, LSB beat first.
// Define JUMP_SEND_PARITY_EN to append an XOR parity beat to every frame.
module jump_flag_sender #(
    parameter int ADDR_W = 32,
    parameter int OUT_W  = 8,
    parameter int DEPTH  = 4
) (
    input logic              clk,
    input logic              rst,
    jump_flag_sender_if.slave bus
);
    localparam int BEATS  = ADDR_W / OUT_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND
`ifdef JUMP_SEND_PARITY_EN
        , S_PAR
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [ADDR_W-1:0]   shift_q;
    logic [BEAT_W-1:0]   beat_cnt_q;
    logic                overflow_q;
    logic                pop;
    logic                push_ok;
    logic                beat_fire;
    logic                last_beat;
    logic                valid;

`ifdef JUMP_SEND_PARITY_EN
    logic [OUT_W-1:0]    par_q;
`endif

    assign valid     = (state_q != S_IDLE);
    assign beat_fire = valid && bus.ready_i;
    assign last_beat = (beat_cnt_q == BEAT_W'(BEATS - 1));
    // A full queue still takes a push when the head leaves in the same cycle.
    assign push_ok   = !rst && bus.start_i && ((count_q != CNT_W'(DEPTH)) || pop);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (beat_fire && last_beat) begin
`ifdef JUMP_SEND_PARITY_EN
                    state_d = S_PAR;
`else
                    if (count_q != '0) pop = 1'b1;
                    else               state_d = S_IDLE;
`endif
                end
            end
`ifdef JUMP_SEND_PARITY_EN
            S_PAR: begin
                if (beat_fire) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = S_SEND;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the entry storage is deliberately not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= bus.jump_addr_i;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            beat_cnt_q <= '0;
            overflow_q <= 1'b0;
`ifdef JUMP_SEND_PARITY_EN
            par_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            overflow_q <= bus.start_i && !push_ok;

            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);

            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            if (pop) begin
                shift_q    <= mem[rd_ptr_q];
                beat_cnt_q <= '0;
`ifdef JUMP_SEND_PARITY_EN
                par_q      <= '0;
`endif
            end else if (state_q == S_SEND && beat_fire) begin
                shift_q    <= shift_q >> OUT_W;
                beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
`ifdef JUMP_SEND_PARITY_EN
                par_q      <= par_q ^ shift_q[OUT_W-1:0];
`endif
            end
        end
    end

`ifdef JUMP_SEND_PARITY_EN
    assign bus.result_o = (state_q == S_PAR) ? par_q : shift_q[OUT_W-1:0];
`else
    assign bus.result_o = shift_q[OUT_W-1:0];
`endif
    assign bus.valid_o    = valid;
    assign bus.busy_o     = (state_q != S_IDLE) || (count_q != '0);
    assign bus.full_o     = (count_q == CNT_W'(DEPTH));
    assign bus.overflow_o = overflow_q;
endmodule

// File: tb/tb_jump_flag_sender.sv
// Random and directed stimulus for jump_flag_sender, compared each cycle against a queue-based model.
module tb_jump_flag_sender;
    localparam int ADDR_W = 32;
    localparam int OUT_W  = 8;
    localparam int DEPTH  = 4;
    localparam int BEATS  = ADDR_W / OUT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    jump_flag_sender_if #(.ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus ();

    jump_flag_sender #(.ADDR_W(ADDR_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: pending entries, beats still owed for the frame on the wire, and the overflow pulse.
    logic [ADDR_W-1:0] q_pend [$];
    logic [OUT_W-1:0]  q_beats [$];
    bit                exp_ovf = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic load_frame(input logic [ADDR_W-1:0] a);
        logic [OUT_W-1:0] p;
        p = '0;
        for (int b = 0; b < BEATS; b++) begin
            q_beats.push_back(a[b*OUT_W +: OUT_W]);
            p = p ^ a[b*OUT_W +: OUT_W];
        end
`ifdef JUMP_SEND_PARITY_EN
        q_beats.push_back(p);
`endif
    endtask

    task automatic model_step(input logic rs, input logic s, input logic [ADDR_W-1:0] a, input logic r);
        bit do_pop;
        bit accept;
        if (rs) begin
            q_pend.delete();
            q_beats.delete();
            exp_ovf = 1'b0;
            return;
        end
        if (q_beats.size() != 0 && r) void'(q_beats.pop_front());
        do_pop = (q_beats.size() == 0) && (q_pend.size() != 0);
        accept = s && ((q_pend.size() < DEPTH) || do_pop);
        if (do_pop) load_frame(q_pend.pop_front());
        if (accept) q_pend.push_back(a);
        exp_ovf = s && !accept;
    endtask

    task automatic compare_outputs();
        bit act;
        act = (q_beats.size() != 0);
        check("valid", 64'(bus.valid_o), 64'(act));
        check("busy", 64'(bus.busy_o), 64'(act || q_pend.size() != 0));
        check("full", 64'(bus.full_o), 64'(q_pend.size() == DEPTH));
        check("overflow", 64'(bus.overflow_o), 64'(exp_ovf));
        if (act) check("result", 64'(bus.result_o), 64'(q_beats[0]));
    endtask

    task automatic cycle(input logic rs, input logic s, input logic [ADDR_W-1:0] a, input logic r);
        @(negedge clk);
        if (chk_en) compare_outputs();
        rst             = rs;
        bus.start_i     = s;
        bus.jump_addr_i = a;
        bus.ready_i     = r;
        model_step(rs, s, a, r);
        if (rs) chk_en = 1'b1;
    endtask

    initial begin
        bus.start_i     = 1'b0;
        bus.jump_addr_i = '0;
        bus.ready_i     = 1'b0;

        repeat (2) cycle(1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("rst_result", 64'(bus.result_o), 64'h0);
        check("rst_valid", 64'(bus.valid_o), 64'h0);

        // Single frame, consumer always ready
        cycle(1'b0, 1'b1, 32'h1234_5678, 1'b1);
        repeat (9) cycle(1'b0, 1'b0, '0, 1'b1);

        // Back-to-back frames with no bubble
        cycle(1'b0, 1'b1, 32'hAABB_CCDD, 1'b1);
        cycle(1'b0, 1'b1, 32'h1122_3344, 1'b1);
        repeat (14) cycle(1'b0, 1'b0, '0, 1'b1);

        // Backpressure holds the first beat
        cycle(1'b0, 1'b1, 32'h1234_5678, 1'b0);
        repeat (7) cycle(1'b0, 1'b0, '0, 1'b0);
        repeat (8) cycle(1'b0, 1'b0, '0, 1'b1);

        // Fill the queue while stalled; the sixth push must drop
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, ADDR_W'(32'hC0DE_0000 + i), 1'b0);
        repeat (3) cycle(1'b0, 1'b0, '0, 1'b0);
        repeat (30) cycle(1'b0, 1'b0, '0, 1'b1);

        // Reset in the middle of a frame, then a clean frame
        cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b1, 32'h0BAD_0BAD, 1'b1);
        cycle(1'b0, 1'b1, 32'hCAFE_F00D, 1'b1);
        repeat (9) cycle(1'b0, 1'b0, '0, 1'b1);

        // Random traffic with sporadic reset
        for (int i = 0; i < 3000; i++) begin
            cycle(1'b0 || ($urandom_range(0, 249) == 0),
                  ($urandom_range(0, 2) == 0),
                  ADDR_W'($urandom),
                  ($urandom_range(0, 3) != 0));
        end
        repeat (40) cycle(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        compare_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
